// File: rtl/nco_cos_sin_if.sv
// Control and sample bus of the quadrature NCO: phase programming in, cos/sin samples out.
interface nco_cos_sin_if #(
  parameter int unsigned PHASE_W = 9,
  parameter int unsigned OUT_W   = 48
);
  logic                      en;
  logic                      sync;
  logic [PHASE_W-1:0]        phase_init;
  logic [PHASE_W-1:0]        phase_inc;
  logic [PHASE_W-1:0]        phase;
  logic signed [OUT_W-1:0]   cos;
  logic signed [OUT_W-1:0]   sin;
  logic                      out_valid;
  logic                      wrap;

  modport master (
    output en, sync, phase_init, phase_inc,
    input  phase, cos, sin, out_valid, wrap
  );

  modport slave (
    input  en, sync, phase_init, phase_inc,
    output phase, cos, sin, out_valid, wrap
  );
endinterface

// File: rtl/nco_cos_sin.sv
// Modulo-N phase accumulator NCO with quarter-wave cosine ROM, quadrant expansion
// and a fixed 3-stage pipeline (index/sign, ROM read, sign apply).
module nco_cos_sin #(
  parameter int unsigned PHASE_STEPS = 500,
  parameter int unsigned PHASE_W     = $clog2(PHASE_STEPS),
  parameter int unsigned OUT_W       = 48,
  parameter string       TABLE_FILE  = "cos_q500.hex"
) (
  input  logic          clk,
  input  logic          rst,
  nco_cos_sin_if.slave  bus
);

  localparam int unsigned QTR   = PHASE_STEPS / 4;
  localparam int unsigned IDX_W = $clog2(QTR + 1);
  localparam logic [PHASE_W:0] STEPS_X = (PHASE_W+1)'(PHASE_STEPS);
  localparam logic [PHASE_W:0] Q1_X    = (PHASE_W+1)'(QTR);
  localparam logic [PHASE_W:0] Q2_X    = (PHASE_W+1)'(2 * QTR);
  localparam logic [PHASE_W:0] Q3_X    = (PHASE_W+1)'(3 * QTR);

  // ROM contents are the TABLE_FILE values, generated at elaboration from the same rounding rule.
  function automatic logic [OUT_W-1:0] table_entry(input int unsigned k);
    real scale;
    real ang;
    scale = real'((longint'(1) <<< (OUT_W - 1)) - longint'(1));
    ang   = 2.0 * 3.14159265358979323846 * real'(k) / real'(PHASE_STEPS);
    return OUT_W'(longint'(scale * $cos(ang)));
  endfunction

  function automatic logic [PHASE_W-1:0] reduce(input logic [PHASE_W-1:0] x);
    logic [PHASE_W:0] xe;
    xe = {1'b0, x};
    return (xe >= STEPS_X) ? PHASE_W'(xe - STEPS_X) : x;
  endfunction

  logic [OUT_W-1:0] w_rom [QTR+1];
  for (genvar k = 0; k <= int'(QTR); k++) begin : g_rom
    localparam logic [OUT_W-1:0] ENTRY = table_entry(k);
    assign w_rom[k] = ENTRY;
  end

  logic [PHASE_W-1:0] r_acc;
  logic [PHASE_W-1:0] w_p;
  logic [PHASE_W-1:0] w_inc_red;
  logic [PHASE_W:0]   w_sum;
  logic [PHASE_W:0]   w_pe;
  logic [PHASE_W:0]   w_rem;
  logic [1:0]         w_quad;
  logic               w_wrap;
  logic [PHASE_W-1:0] w_acc_next;
  logic [IDX_W-1:0]   w_cidx;
  logic [IDX_W-1:0]   w_sidx;

  logic               r_s1_valid, r_s1_wrap, r_s1_cneg, r_s1_sneg;
  logic [IDX_W-1:0]   r_s1_cidx, r_s1_sidx;
  logic               r_s2_valid, r_s2_wrap, r_s2_cneg, r_s2_sneg;
  logic [OUT_W-1:0]   r_s2_cmag, r_s2_smag;
  logic               r_valid, r_wrap;
  logic [OUT_W-1:0]   r_cos, r_sin;

  // Sample phase, next accumulator and quadrant fold.
  always_comb begin
    w_inc_red = reduce(bus.phase_inc);
    w_p       = bus.sync ? reduce(bus.phase_init) : r_acc;
    w_sum     = {1'b0, w_p} + {1'b0, w_inc_red};
    w_wrap    = (w_sum >= STEPS_X);
    w_acc_next = bus.en ? (w_wrap ? PHASE_W'(w_sum - STEPS_X) : PHASE_W'(w_sum)) : w_p;
    w_pe      = {1'b0, w_p};
    w_quad    = 2'd0;
    w_rem     = w_pe;
    if (w_pe >= Q3_X) begin
      w_quad = 2'd3;
      w_rem  = w_pe - Q3_X;
    end else if (w_pe >= Q2_X) begin
      w_quad = 2'd2;
      w_rem  = w_pe - Q2_X;
    end else if (w_pe >= Q1_X) begin
      w_quad = 2'd1;
      w_rem  = w_pe - Q1_X;
    end
    w_cidx = IDX_W'(w_quad[0] ? (Q1_X - w_rem) : w_rem);
    w_sidx = IDX_W'(w_quad[0] ? w_rem : (Q1_X - w_rem));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_wrap  <= 1'b0;
      r_s1_cneg  <= 1'b0;
      r_s1_sneg  <= 1'b0;
      r_s1_cidx  <= '0;
      r_s1_sidx  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_wrap  <= 1'b0;
      r_s2_cneg  <= 1'b0;
      r_s2_sneg  <= 1'b0;
      r_s2_cmag  <= '0;
      r_s2_smag  <= '0;
      r_valid    <= 1'b0;
      r_wrap     <= 1'b0;
      r_cos      <= '0;
      r_sin      <= '0;
    end else begin
      r_acc      <= w_acc_next;
      r_s1_valid <= bus.en;
      r_s1_wrap  <= bus.en & w_wrap;
      r_s1_cneg  <= w_quad[1] ^ w_quad[0];
      r_s1_sneg  <= w_quad[1];
      r_s1_cidx  <= w_cidx;
      r_s1_sidx  <= w_sidx;
      r_s2_valid <= r_s1_valid;
      r_s2_wrap  <= r_s1_wrap;
      r_s2_cneg  <= r_s1_cneg;
      r_s2_sneg  <= r_s1_sneg;
      r_s2_cmag  <= w_rom[r_s1_cidx];
      r_s2_smag  <= w_rom[r_s1_sidx];
      r_valid    <= r_s2_valid;
      r_wrap     <= r_s2_valid & r_s2_wrap;
      // Bubbles leave the last valid sample on the outputs.
      if (r_s2_valid) begin
        r_cos <= r_s2_cneg ? OUT_W'(-r_s2_cmag) : r_s2_cmag;
        r_sin <= r_s2_sneg ? OUT_W'(-r_s2_smag) : r_s2_smag;
      end
    end
  end

  assign bus.phase     = r_acc;
  assign bus.cos       = r_cos;
  assign bus.sin       = r_sin;
  assign bus.out_valid = r_valid;
  assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_nco_cos_sin.sv
// Scoreboard bench for nco_cos_sin: angle-based reference model feeds an expectation queue.
module tb_nco_cos_sin;
  localparam int N  = 500;
  localparam int PW = 9;
  localparam int OW = 48;
  localparam int Q  = N / 4;

  typedef struct {
    int     cyc;
    longint c;
    longint s;
    bit     w;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nco_cos_sin_if #(.PHASE_W(PW), .OUT_W(OW)) bus();

  nco_cos_sin #(
    .PHASE_STEPS(N), .PHASE_W(PW), .OUT_W(OW), .TABLE_FILE("cos_q500.hex")
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  exp_t   q[$];
  longint tbl[Q+1];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     m_acc = 0;
  int     exp_phase = 0;
  bit     started = 1'b0;
  longint last_c = 0;
  longint last_s = 0;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
    end
  endtask

  function automatic int red(input int x);
    return (x >= N) ? x - N : x;
  endfunction

  // cos of angle 2*pi*a/N from its first-quadrant magnitude using evenness and the half-turn flip.
  function automatic longint cosv(input int a);
    int b;
    b = a;
    if (b > N / 2) b = N - b;
    if (b > Q) return -tbl[N / 2 - b];
    return tbl[b];
  endfunction

  task automatic step(input bit r, input bit e, input bit sy, input int init, input int inc);
    int p;
    int s;
    @(posedge clk);
    #1;
    rst            = r;
    bus.en         = e;
    bus.sync       = sy;
    bus.phase_init = PW'(init);
    bus.phase_inc  = PW'(inc);
    cyc++;
    exp_phase = m_acc;
    if (r) begin
      m_acc = 0;
    end else begin
      p = sy ? red(init) : m_acc;
      if (e) begin
        s = p + red(inc);
        q.push_back('{cyc, cosv(p), cosv((p + N - Q) % N), s >= N});
        m_acc = s % N;
      end else begin
        m_acc = p;
      end
    end
    started = 1'b1;
  endtask

  // Monitor: compares every cycle, decoupled from the stimulus.
  initial begin : monitor
    exp_t e;
    bit   ev;
    bit   rst_prev;
    rst_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("phase", longint'(bus.phase), longint'(exp_phase));
        if (rst_prev) chk("wrap_after_rst", longint'(bus.wrap), 0);
        ev = (q.size() > 0) && (q[0].cyc + 3 == cyc);
        chk("out_valid", longint'(bus.out_valid), longint'(ev));
        if (ev) begin
          e = q.pop_front();
          chk("cos", longint'(bus.cos), e.c);
          chk("sin", longint'(bus.sin), e.s);
          chk("wrap", longint'(bus.wrap), longint'(e.w));
          last_c = e.c;
          last_s = e.s;
        end else begin
          chk("hold_cos", longint'(bus.cos), last_c);
          chk("hold_sin", longint'(bus.sin), last_s);
        end
        rst_prev = rst;
        if (rst) begin
          q.delete();
          last_c = 0;
          last_s = 0;
        end
      end
    end
  end

  initial begin : stim
    real scale;
    real ang;
    int  mode;
    int  inc;
    bus.en = 1'b0;
    bus.sync = 1'b0;
    bus.phase_init = '0;
    bus.phase_inc = '0;
    scale = real'((longint'(1) <<< (OW - 1)) - longint'(1));
    for (int k = 0; k <= Q; k++) begin
      ang    = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
      tbl[k] = longint'(scale * $cos(ang));
    end

    repeat (2) step(1'b1, 1'b0, 1'b0, 0, 0);
    // Full period at unit step, phase returns to 0.
    repeat (N) step(1'b0, 1'b1, 1'b0, 0, 1);
    // Quarter-turn step: (S,0),(0,S),(-S,0),(0,-S).
    repeat (12) step(1'b0, 1'b1, 1'b0, 0, 125);
    // One-cycle reset mid-stream, then run backwards from 0.
    step(1'b1, 1'b1, 1'b0, 0, 125);
    repeat (40) step(1'b0, 1'b1, 1'b0, 0, 499);
    // Sync with out-of-range init while streaming.
    repeat (10) step(1'b0, 1'b1, 1'b0, 0, 1);
    step(1'b0, 1'b1, 1'b1, 510, 1);
    repeat (5) step(1'b0, 1'b1, 1'b0, 0, 1);
    step(1'b0, 1'b0, 1'b1, 507, 1);
    repeat (4) step(1'b0, 1'b1, 1'b0, 0, 0);
    // Random gating, sync, steps and occasional reset.
    for (int i = 0; i < 2000; i++) begin
      mode = int'($urandom_range(0, 7));
      case (mode)
        0: inc = 0;
        1: inc = 1;
        2: inc = 125;
        3: inc = 499;
        default: inc = int'($urandom_range(0, 511));
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 15) == 0, int'($urandom_range(0, 511)), inc);
    end
    repeat (6) step(1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    #1;
    chk("drained", longint'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
